// File: rtl/key_event_conditioner_if.sv
// Event handshake between key_event_conditioner (master) and the vending FSM (slave).
interface key_event_conditioner_if;
  logic       valid;
  logic [1:0] code;
  logic       ready;

  modport master (output valid, output code, input ready);
  modport slave  (input valid, input code, output ready);
endinterface

// File: rtl/key_event_conditioner.sv
// Key synchroniser, debouncer and press-event FIFO for the four vending keys.
// Optional auto-repeat of held keys is enabled by defining KEY_AUTO_REPEAT_EN.
module key_event_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 2,
  parameter int unsigned REPEAT_DELAY    = 50,
  parameter int unsigned REPEAT_PERIOD   = 20
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [3:0]                     key_in,
  key_event_conditioner_if.master        evt,
  output logic [3:0]                     key_level,
  output logic [2:0]                     fifo_count,
  output logic                           evt_drop
);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255 ||
      REPEAT_DELAY < 1 || REPEAT_DELAY > 65535 ||
      REPEAT_PERIOD < 1 || REPEAT_PERIOD > 65535) begin : g_bad_param
    $error("key_event_conditioner: parameter out of range");
  end

  localparam logic [7:0] DEB_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic [3:0] s1_q, s2_q;
  logic [3:0] stable_q, stable_d;
  logic [7:0] cnt_q [4];
  logic [7:0] cnt_d [4];
  logic [3:0] pending_q, pending_d;
  logic [3:0] press, key_evt;
  logic [3:0] grant, grant_eff;
  logic [1:0] push_code;
  logic       found;
  logic       push, pop, full;
  logic       drop_q, drop_d;

  logic [1:0] mem_q [4];
  logic [1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0] count_q, count_d;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      stable_d[k] = stable_q[k];
      cnt_d[k]    = '0;
      if (s2_q[k] != stable_q[k]) begin
        if (cnt_q[k] == DEB_LAST) begin
          stable_d[k] = ~stable_q[k];
        end else begin
          cnt_d[k] = cnt_q[k] + 8'd1;
        end
      end
    end
  end

  assign press = stable_d & ~stable_q;

`ifdef KEY_AUTO_REPEAT_EN
  logic [15:0] rpt_cnt_q [4];
  logic [15:0] rpt_cnt_d [4];
  logic [3:0]  rpt_arm_q, rpt_arm_d;
  logic [3:0]  rpt_fire;

  // First repeat fires REPEAT_DELAY cycles after the stable rise, then every REPEAT_PERIOD.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      rpt_cnt_d[k] = '0;
      rpt_arm_d[k] = 1'b0;
      rpt_fire[k]  = 1'b0;
      if (stable_q[k] && stable_d[k]) begin
        rpt_arm_d[k] = rpt_arm_q[k];
        if (rpt_cnt_q[k] + 16'd1 ==
            (rpt_arm_q[k] ? 16'(REPEAT_PERIOD) : 16'(REPEAT_DELAY))) begin
          rpt_fire[k]  = 1'b1;
          rpt_arm_d[k] = 1'b1;
        end else begin
          rpt_cnt_d[k] = rpt_cnt_q[k] + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < 4; k++) rpt_cnt_q[k] <= '0;
      rpt_arm_q <= '0;
    end else begin
      for (int k = 0; k < 4; k++) rpt_cnt_q[k] <= rpt_cnt_d[k];
      rpt_arm_q <= rpt_arm_d;
    end
  end

  assign key_evt = press | rpt_fire;
`else
  assign key_evt = press;
`endif

  always_comb begin
    grant     = '0;
    push_code = '0;
    found     = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (pending_q[k] && !found) begin
        grant[k]  = 1'b1;
        push_code = 2'(k);
        found     = 1'b1;
      end
    end
  end

  assign full      = (count_q == 3'd4);
  assign pop       = (count_q != 3'd0) && evt.ready;
  assign push      = (|pending_q) && (!full || pop);
  assign grant_eff = push ? grant : 4'b0000;

  // A new event is lost only if its pending bit is still occupied after this cycle's push.
  always_comb begin
    pending_d = (pending_q & ~grant_eff) | key_evt;
    drop_d    = drop_q | (|(key_evt & pending_q & ~grant_eff));
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 2'd1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 2'd1 : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) count_d = count_q + 3'd1;
    else if (pop && !push) count_d = count_q - 3'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_q      <= '0;
      s2_q      <= '0;
      stable_q  <= '0;
      for (int k = 0; k < 4; k++) cnt_q[k] <= '0;
      pending_q <= '0;
      drop_q    <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      s1_q      <= key_in;
      s2_q      <= s1_q;
      stable_q  <= stable_d;
      for (int k = 0; k < 4; k++) cnt_q[k] <= cnt_d[k];
      pending_q <= pending_d;
      drop_q    <= drop_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_code;
  end

  assign evt.valid  = (count_q != 3'd0);
  assign evt.code   = (count_q != 3'd0) ? mem_q[rd_ptr_q] : 2'd0;
  assign key_level  = stable_q;
  assign fifo_count = count_q;
  assign evt_drop   = drop_q;

endmodule

// File: tb/tb_key_event_conditioner.sv
// Directed bench for key_event_conditioner (default build, DEBOUNCE_CYCLES=2).
module tb_key_event_conditioner;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] key_in;
  logic [3:0] key_level;
  logic [2:0] fifo_count;
  logic       evt_drop;

  int checks = 0;
  int errors = 0;

  key_event_conditioner_if evt_if ();

  key_event_conditioner #(
    .DEBOUNCE_CYCLES (2),
    .REPEAT_DELAY    (50),
    .REPEAT_PERIOD   (20)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .key_in     (key_in),
    .evt        (evt_if),
    .key_level  (key_level),
    .fifo_count (fifo_count),
    .evt_drop   (evt_drop)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Hold one key for three samples, then release and let it debounce low.
  task automatic press(input int k);
    key_in = 4'(1 << k);
    tick(3);
    key_in = 4'b0000;
    tick(5);
  endtask

  logic [1:0] exp_codes [5];
  int seen;

  initial begin
    exp_codes[0] = 2'd0;
    exp_codes[1] = 2'd1;
    exp_codes[2] = 2'd2;
    exp_codes[3] = 2'd3;
    exp_codes[4] = 2'd0;

    reset        = 1'b0;
    key_in       = 4'b0000;
    evt_if.ready = 1'b0;
    tick(2);
    chk("rst_valid", 32'(evt_if.valid), 32'd0);
    chk("rst_code",  32'(evt_if.code),  32'd0);
    chk("rst_level", 32'(key_level),    32'd0);
    chk("rst_count", 32'(fifo_count),   32'd0);
    chk("rst_drop",  32'(evt_drop),     32'd0);
    reset = 1'b1;
    tick(2);

    // Single press of key 2, five samples high
    key_in       = 4'b0100;
    evt_if.ready = 1'b1;
    tick(3);
    chk("sp_level_e2", 32'(key_level), 32'd0);
    tick(1);
    chk("sp_level_e3", 32'(key_level), 32'h4);
    chk("sp_valid_e3", 32'(evt_if.valid), 32'd0);
    tick(1);
    chk("sp_valid_e4", 32'(evt_if.valid), 32'd1);
    chk("sp_code_e4",  32'(evt_if.code),  32'd2);
    chk("sp_count_e4", 32'(fifo_count),   32'd1);
    key_in = 4'b0000;
    tick(1);
    chk("sp_valid_e5", 32'(evt_if.valid), 32'd0);
    chk("sp_count_e5", 32'(fifo_count),   32'd0);
    tick(3);
    chk("sp_level_e8", 32'(key_level), 32'd0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (evt_if.valid) seen++;
    end
    chk("sp_no_second", 32'(seen), 32'd0);

    // One-cycle glitch on key 0
    key_in = 4'b0001;
    tick(1);
    key_in = 4'b0000;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (evt_if.valid || key_level != 4'b0000) seen++;
    end
    chk("glitch_reject", 32'(seen), 32'd0);

    // Simultaneous keys 1 and 3 with the consumer stalled
    evt_if.ready = 1'b0;
    key_in       = 4'b1010;
    tick(4);
    chk("sim_count_e3", 32'(fifo_count), 32'd0);
    tick(1);
    chk("sim_count_e4", 32'(fifo_count), 32'd1);
    chk("sim_code_e4",  32'(evt_if.code), 32'd1);
    tick(1);
    chk("sim_count_e5", 32'(fifo_count), 32'd2);
    chk("sim_code_e5",  32'(evt_if.code), 32'd1);
    evt_if.ready = 1'b1;
    tick(1);
    chk("sim_count_pop1", 32'(fifo_count), 32'd1);
    chk("sim_code_pop1",  32'(evt_if.code), 32'd3);
    tick(1);
    chk("sim_valid_pop2", 32'(evt_if.valid), 32'd0);
    key_in = 4'b0000;
    tick(6);
    chk("sim_level_rel", 32'(key_level), 32'd0);
    chk("sim_no_drop",   32'(evt_drop),  32'd0);

    // Backpressure: fill the FIFO, hold one pending, then overflow it
    evt_if.ready = 1'b0;
    press(0);
    press(1);
    press(2);
    press(3);
    chk("bp_full_count", 32'(fifo_count), 32'd4);
    press(0);
    chk("bp_held_count", 32'(fifo_count), 32'd4);
    chk("bp_held_nodrop", 32'(evt_drop), 32'd0);
    press(0);
    chk("bp_drop", 32'(evt_drop), 32'd1);
    evt_if.ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_drain_valid%0d", i), 32'(evt_if.valid), 32'd1);
      chk($sformatf("bp_drain_code%0d", i),  32'(evt_if.code), 32'(exp_codes[i]));
      tick(1);
    end
    chk("bp_empty_valid", 32'(evt_if.valid), 32'd0);
    chk("bp_empty_count", 32'(fifo_count),   32'd0);
    chk("bp_drop_sticky", 32'(evt_drop),     32'd1);

    // Reset with three events queued and key 0 held across it
    evt_if.ready = 1'b0;
    press(1);
    press(2);
    press(3);
    chk("mid_count", 32'(fifo_count), 32'd3);
    key_in = 4'b0001;
    reset  = 1'b0;
    tick(1);
    reset = 1'b1;
    chk("mid_rst_count", 32'(fifo_count),   32'd0);
    chk("mid_rst_valid", 32'(evt_if.valid), 32'd0);
    chk("mid_rst_drop",  32'(evt_drop),     32'd0);
    chk("mid_rst_level", 32'(key_level),    32'd0);
    tick(4);
    chk("mid_held_e3", 32'(evt_if.valid), 32'd0);
    tick(1);
    chk("mid_held_valid", 32'(evt_if.valid), 32'd1);
    chk("mid_held_code",  32'(evt_if.code),  32'd0);
    chk("mid_held_count", 32'(fifo_count),   32'd1);
    key_in       = 4'b0000;
    evt_if.ready = 1'b1;
    tick(1);
    chk("mid_pop_count", 32'(fifo_count), 32'd0);
    tick(8);
    chk("mid_final_valid", 32'(evt_if.valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
